// File: rtl/usb_pkg.sv
// usb_pkg: PID and FSM state types plus the token CRC5 helper shared by the token decoder
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_B1,
        S_WAIT_EOP,
        S_CHECK,
        S_DISCARD
    } tok_state_t;

    // Expected CRC field as it sits in B2[7:3] for the 11-bit {endp,addr} payload
    function automatic logic [4:0] crc5_11(input logic [10:0] d);
        logic [4:0] r;
        logic [4:0] f;
        logic       fb;
        r = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb = d[i] ^ r[4];
            r  = {r[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        for (int i = 0; i < 5; i++) f[i] = ~r[4-i];
        return f;
    endfunction

endpackage

// File: rtl/usb_token_regs.sv
// usb_token_regs: captures the PID/B1/B2 bytes of a packet and holds the last reported token fields
// Optional SOF frame number register is built when USB_TOKEN_SOF_EN is defined.
module usb_token_regs (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rx_data,
    input  logic        cap_pid,
    input  logic        cap_b1,
    input  logic        cap_b2,
    input  logic        load_tok,
`ifdef USB_TOKEN_SOF_EN
    input  logic        load_sof,
    output logic [10:0] frame_num,
`endif
    output logic [3:0]  pid_q,
    output logic [7:0]  b1_q,
    output logic [7:0]  b2_q,
    output logic [3:0]  tok_pid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp
);

    // Byte capture for the packet currently being received
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pid_q <= '0;
            b1_q  <= '0;
            b2_q  <= '0;
        end else begin
            if (cap_pid) pid_q <= rx_data[3:0];
            if (cap_b1)  b1_q  <= rx_data;
            if (cap_b2)  b2_q  <= rx_data;
        end
    end

    // Reported fields change only when a good token is strobed
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tok_pid  <= '0;
            tok_addr <= '0;
            tok_endp <= '0;
        end else if (load_tok) begin
            tok_pid  <= pid_q;
            tok_addr <= b1_q[6:0];
            tok_endp <= {b2_q[2:0], b1_q[7]};
        end
    end

`ifdef USB_TOKEN_SOF_EN
    // Frame number of the last good SOF
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) frame_num <= '0;
        else if (load_sof) frame_num <= {b2_q[2:0], b1_q};
    end
`endif

endmodule

// File: rtl/usb_token_decoder.sv
// usb_token_decoder: validates OUT/IN/SETUP token packets (PID, length, CRC5, address) into one-cycle strobes
// Define USB_TOKEN_SOF_EN to also accept SOF packets (sof_valid / frame_num outputs).
module usb_token_decoder
    import usb_pkg::*;
#(
    parameter bit CHECK_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        rx_error,
    input  logic [6:0]  dev_addr,
    output logic        tok_valid,
    output logic [3:0]  tok_pid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic        tok_pid_err,
    output logic        tok_crc_err,
    output logic        tok_len_err
`ifdef USB_TOKEN_SOF_EN
    ,
    output logic        sof_valid,
    output logic [10:0] frame_num
`endif
);

    tok_state_t state, state_d;
    logic       cap_pid, cap_b1, cap_b2, load_tok, pe_d, ce_d, le_d;
    logic       pid_ok, is_tok, crc_ok, addr_ok, sop_in, byte_in;
    logic [3:0] pid_q;
    logic [7:0] b1_q, b2_q;
`ifdef USB_TOKEN_SOF_EN
    logic       load_sof, is_sof;
    assign is_sof = pid_q == PID_SOF;
    assign is_tok = rx_data[3:0] == PID_OUT || rx_data[3:0] == PID_IN ||
                    rx_data[3:0] == PID_SETUP || rx_data[3:0] == PID_SOF;
`else
    assign is_tok = rx_data[3:0] == PID_OUT || rx_data[3:0] == PID_IN ||
                    rx_data[3:0] == PID_SETUP;
`endif

    assign pid_ok  = rx_data[7:4] == ~rx_data[3:0];
    assign crc_ok  = crc5_11({b2_q[2:0], b1_q}) == b2_q[7:3];
    assign addr_ok = !CHECK_ADDR || b1_q[6:0] == dev_addr;
    assign sop_in  = rx_sop && rx_data_valid;
    assign byte_in = rx_data_valid && !rx_sop;

    usb_token_regs u_regs (
        .clk      (clk),
        .n_rst    (n_rst),
        .rx_data  (rx_data),
        .cap_pid  (cap_pid),
        .cap_b1   (cap_b1),
        .cap_b2   (cap_b2),
        .load_tok (load_tok),
`ifdef USB_TOKEN_SOF_EN
        .load_sof (load_sof),
        .frame_num(frame_num),
`endif
        .pid_q    (pid_q),
        .b1_q     (b1_q),
        .b2_q     (b2_q),
        .tok_pid  (tok_pid),
        .tok_addr (tok_addr),
        .tok_endp (tok_endp)
    );

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else state <= state_d;
    end

    // Next state, byte capture and strobe decisions; a new SOP always restarts in PID
    always_comb begin
        state_d  = state;
        cap_pid  = 1'b0;
        cap_b1   = 1'b0;
        cap_b2   = 1'b0;
        load_tok = 1'b0;
        pe_d     = 1'b0;
        ce_d     = 1'b0;
        le_d     = 1'b0;
`ifdef USB_TOKEN_SOF_EN
        load_sof = 1'b0;
`endif
        if (rx_error) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_PID: begin
                    if (rx_eop) begin
                        le_d    = 1'b1;
                        state_d = S_IDLE;
                    end else if (byte_in) begin
                        cap_b1  = 1'b1;
                        state_d = S_B1;
                    end
                end
                S_B1: begin
                    if (rx_eop) begin
                        le_d    = 1'b1;
                        state_d = S_IDLE;
                    end else if (byte_in) begin
                        cap_b2  = 1'b1;
                        state_d = S_WAIT_EOP;
                    end
                end
                S_WAIT_EOP: begin
                    if (rx_eop) begin
                        state_d = S_CHECK;
                        ce_d    = !crc_ok;
`ifdef USB_TOKEN_SOF_EN
                        load_sof = crc_ok && is_sof;
                        load_tok = crc_ok && !is_sof && addr_ok;
`else
                        load_tok = crc_ok && addr_ok;
`endif
                    end else if (byte_in) begin
                        le_d    = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
                S_DISCARD: state_d = rx_eop ? S_IDLE : S_DISCARD;
                default:   state_d = S_IDLE;
            endcase
            if (sop_in) begin
                cap_pid = 1'b1;
                pe_d    = !pid_ok;
                state_d = pid_ok && is_tok ? S_PID : S_DISCARD;
            end
        end
    end

    // Registered one-cycle strobes
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) {tok_valid, tok_pid_err, tok_crc_err, tok_len_err} <= '0;
        else {tok_valid, tok_pid_err, tok_crc_err, tok_len_err} <= {load_tok, pe_d, ce_d, le_d};
    end

`ifdef USB_TOKEN_SOF_EN
    // SOF strobe
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) sof_valid <= 1'b0;
        else sof_valid <= load_sof;
    end
`endif

endmodule

// File: tb/tb_usb_token_decoder.sv
// tb_usb_token_decoder: table-driven packets plus hand sequences, scoreboard on two decoders (address filter on/off)
module tb_usb_token_decoder;

    localparam logic [4:0] S_SOF = 5'b10000;
    localparam logic [4:0] S_V   = 5'b01000;
    localparam logic [4:0] S_PE  = 5'b00100;
    localparam logic [4:0] S_CE  = 5'b00010;
    localparam logic [4:0] S_LE  = 5'b00001;

    typedef struct {
        int          cyc;
        logic [4:0]  st;
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [10:0] fn;
    } ev_t;

    typedef struct {
        logic [7:0] pid, b1, b2;
        int         n;
        logic [6:0] dev;
        bit         pe, le, ce, va, vb;
    } vec_t;

    logic        clk = 1'b0, n_rst = 1'b0;
    logic        rx_data_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_error = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [6:0]  dev_addr = '0;
    logic        va, pea, cea, lea, vb, peb, ceb, leb, sofa, sofb;
    logic [3:0]  pida, endpa, pidb, endpb;
    logic [6:0]  addra, addrb;
    logic [10:0] fna, fnb;

    int   cyc = 0, n_cmp = 0, n_bad = 0;
    ev_t  qa[$], qb[$];
    ev_t  held[2];
    vec_t tbl[13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    usb_token_decoder #(.CHECK_ADDR(1'b1)) dut_a (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_error(rx_error), .dev_addr(dev_addr),
        .tok_valid(va), .tok_pid(pida), .tok_addr(addra), .tok_endp(endpa),
        .tok_pid_err(pea), .tok_crc_err(cea),
`ifdef USB_TOKEN_SOF_EN
        .sof_valid(sofa), .frame_num(fna),
`endif
        .tok_len_err(lea)
    );

    usb_token_decoder #(.CHECK_ADDR(1'b0)) dut_b (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_error(rx_error), .dev_addr(dev_addr),
        .tok_valid(vb), .tok_pid(pidb), .tok_addr(addrb), .tok_endp(endpb),
        .tok_pid_err(peb), .tok_crc_err(ceb),
`ifdef USB_TOKEN_SOF_EN
        .sof_valid(sofb), .frame_num(fnb),
`endif
        .tok_len_err(leb)
    );

`ifndef USB_TOKEN_SOF_EN
    assign sofa = 1'b0;
    assign sofb = 1'b0;
    assign fna  = '0;
    assign fnb  = '0;
`endif

    // Reflected (shift-right) form of the USB CRC5; returns the whole B2 byte
    function automatic logic [7:0] good_b2(input logic [7:0] b1, input logic [2:0] e3);
        logic [10:0] d;
        logic [4:0]  r;
        logic        fb;
        d = {e3, b1};
        r = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb = d[i] ^ r[0];
            r  = (r >> 1) ^ (fb ? 5'b10100 : 5'b00000);
        end
        return {~r, e3};
    endfunction

    function automatic vec_t mk(input logic [7:0] pid, b1, b2, input int n, input logic [6:0] dev,
                                input bit pe, le, ce, va_e, vb_e);
        vec_t v;
        v.pid = pid; v.b1 = b1; v.b2 = b2; v.n = n; v.dev = dev;
        v.pe = pe; v.le = le; v.ce = ce; v.va = va_e; v.vb = vb_e;
        return v;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic drive(input logic v, input logic s, input logic e, input logic er, input logic [7:0] d);
        @(posedge clk);
        #1;
        rx_data_valid = v; rx_sop = s; rx_eop = e; rx_error = er; rx_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Expected event for the cycle after the inputs just driven
    task automatic push(input int d, input logic [4:0] st);
        ev_t e;
        e = held[d];
        e.cyc = cyc + 1;
        e.st = st;
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic tok(input int d, input logic [7:0] pid, input logic [7:0] b1, input logic [7:0] b2);
        held[d].pid  = pid[3:0];
        held[d].addr = b1[6:0];
        held[d].endp = {b2[2:0], b1[7]};
        push(d, S_V);
    endtask

    task automatic tok2(input logic [7:0] pid, input logic [7:0] b1, input logic [7:0] b2);
        tok(0, pid, b1, b2);
        tok(1, pid, b1, b2);
    endtask

    task automatic push2(input logic [4:0] st);
        push(0, st);
        push(1, st);
    endtask

    task automatic clear_held();
        for (int d = 0; d < 2; d++) begin
            held[d].pid = '0; held[d].addr = '0; held[d].endp = '0; held[d].fn = '0;
        end
    endtask

    task automatic mon(input int d, input logic [4:0] act, input logic [3:0] pid, input logic [6:0] addr,
                       input logic [3:0] endp, input logic [10:0] fn);
        ev_t e;
        bit  have;
        have = 0;
        if (d == 0) begin
            while (qa.size() > 0 && qa[0].cyc < cyc) begin
                e = qa.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL dut%0d missed strobe: got none want %b at cycle %0d", d, e.st, e.cyc);
            end
            if (qa.size() > 0 && qa[0].cyc == cyc) begin e = qa.pop_front(); have = 1; end
        end else begin
            while (qb.size() > 0 && qb[0].cyc < cyc) begin
                e = qb.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL dut%0d missed strobe: got none want %b at cycle %0d", d, e.st, e.cyc);
            end
            if (qb.size() > 0 && qb[0].cyc == cyc) begin e = qb.pop_front(); have = 1; end
        end
        if (have) begin
            n_cmp++;
            if (act !== e.st || pid !== e.pid || addr !== e.addr || endp !== e.endp || fn !== e.fn) begin
                n_bad++;
                $display("FAIL dut%0d event cycle %0d: got st=%b pid=%h addr=%h endp=%h fn=%h want st=%b pid=%h addr=%h endp=%h fn=%h",
                         d, cyc, act, pid, addr, endp, fn, e.st, e.pid, e.addr, e.endp, e.fn);
            end
        end else if (act !== 5'b0) begin
            n_cmp++; n_bad++;
            $display("FAIL dut%0d unexpected strobe cycle %0d: got %b want 00000", d, cyc, act);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            mon(0, {sofa, va, pea, cea, lea}, pida, addra, endpa, fna);
            mon(1, {sofb, vb, peb, ceb, leb}, pidb, addrb, endpb, fnb);
        end
    end

    task automatic chk_zero(input string name);
        chk({name, " dut_a"}, {sofa, va, pea, cea, lea, pida, addra, endpa, fna}, '0);
        chk({name, " dut_b"}, {sofb, vb, peb, ceb, leb, pidb, addrb, endpb, fnb}, '0);
    endtask

    initial begin
        clear_held();
        tbl[0]  = mk(8'h2D, 8'h00, 8'h10, 3, 7'h00, 0, 0, 0, 1, 1);
        tbl[1]  = mk(8'h69, 8'h00, 8'h10, 3, 7'h05, 0, 0, 0, 0, 1);
        tbl[2]  = mk(8'hE1, 8'h00, 8'h11, 3, 7'h00, 0, 0, 1, 0, 0);
        tbl[3]  = mk(8'hE1, 8'h55, good_b2(8'h55, 3'b101), 3, 7'h55, 0, 0, 0, 1, 1);
        tbl[4]  = mk(8'h69, 8'hFF, good_b2(8'hFF, 3'b111), 3, 7'h7F, 0, 0, 0, 1, 1);
        tbl[5]  = mk(8'h2D, 8'hD5, good_b2(8'hD5, 3'b010), 3, 7'h33, 0, 0, 0, 0, 1);
        tbl[6]  = mk(8'h2C, 8'h00, 8'h10, 3, 7'h00, 1, 0, 0, 0, 0);
        tbl[7]  = mk(8'h2D, 8'h00, 8'h10, 2, 7'h00, 0, 1, 0, 0, 0);
        tbl[8]  = mk(8'h2D, 8'h00, 8'h10, 4, 7'h00, 0, 1, 0, 0, 0);
        tbl[9]  = mk(8'hC3, 8'h00, 8'h10, 3, 7'h00, 0, 0, 0, 0, 0);
        tbl[10] = mk(8'h69, 8'h00, 8'h10, 1, 7'h00, 0, 1, 0, 0, 0);
        tbl[11] = mk(8'hE1, 8'h55, good_b2(8'h55, 3'b101) ^ 8'h08, 3, 7'h55, 0, 0, 1, 0, 0);
        tbl[12] = mk(8'h5A, 8'h00, 8'h10, 3, 7'h00, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_zero("in reset");
        n_rst = 1'b1;
        idle(2);
        chk_zero("after reset");

        foreach (tbl[i]) begin
            dev_addr = tbl[i].dev;
            drive(1, 1, 0, 0, tbl[i].pid);
            if (tbl[i].pe) push2(S_PE);
            if (tbl[i].n > 1) drive(1, 0, 0, 0, tbl[i].b1);
            if (tbl[i].n > 2) drive(1, 0, 0, 0, tbl[i].b2);
            if (tbl[i].n > 3) begin
                drive(1, 0, 0, 0, 8'h55);
                push2(S_LE);
            end
            idle(1);
            drive(0, 0, 1, 0, 8'h00);
            if (tbl[i].le && tbl[i].n < 4) push2(S_LE);
            if (tbl[i].ce) push2(S_CE);
            if (tbl[i].va) tok(0, tbl[i].pid, tbl[i].b1, tbl[i].b2);
            if (tbl[i].vb) tok(1, tbl[i].pid, tbl[i].b1, tbl[i].b2);
            idle(2);
        end

        // EOP of one packet and SOP of the next in the same cycle
        dev_addr = 7'h00;
        drive(1, 1, 0, 0, 8'h2D); drive(1, 0, 0, 0, 8'h00); drive(1, 0, 0, 0, 8'h10);
        drive(1, 1, 1, 0, 8'h69);
        tok2(8'h2D, 8'h00, 8'h10);
        drive(1, 0, 0, 0, 8'h00); drive(1, 0, 0, 0, 8'h10); idle(1);
        drive(0, 0, 1, 0, 8'h00);
        tok2(8'h69, 8'h00, 8'h10);
        idle(2);

        // Receiver abort mid-packet, then a good OUT
        drive(1, 1, 0, 0, 8'h2D); drive(1, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 1, 8'h00);
        drive(1, 1, 0, 0, 8'hE1); drive(1, 0, 0, 0, 8'h00); drive(1, 0, 0, 0, 8'h10); idle(1);
        drive(0, 0, 1, 0, 8'h00);
        tok2(8'hE1, 8'h00, 8'h10);
        idle(2);

        // New SOP abandons a partial packet
        dev_addr = 7'h55;
        drive(1, 1, 0, 0, 8'h2D); drive(1, 0, 0, 0, 8'h00);
        drive(1, 1, 0, 0, 8'h69); drive(1, 0, 0, 0, 8'h55); drive(1, 0, 0, 0, good_b2(8'h55, 3'b101)); idle(1);
        drive(0, 0, 1, 0, 8'h00);
        tok2(8'h69, 8'h55, good_b2(8'h55, 3'b101));
        idle(2);
        chk("held pid a", pida, 4'h9);
        chk("held endp b", endpb, 4'hA);

        // SOF: accepted only when the feature is built, never as tok_valid
        dev_addr = 7'h11;
        drive(1, 1, 0, 0, 8'hA5); drive(1, 0, 0, 0, 8'h34); drive(1, 0, 0, 0, good_b2(8'h34, 3'b101)); idle(1);
        drive(0, 0, 1, 0, 8'h00);
`ifdef USB_TOKEN_SOF_EN
        for (int d = 0; d < 2; d++) begin
            held[d].fn = {3'b101, 8'h34};
            push(d, S_SOF);
        end
`endif
        idle(2);

        // Reset after B1 drops the packet and clears the held fields
        dev_addr = 7'h00;
        drive(1, 1, 0, 0, 8'h2D); drive(1, 0, 0, 0, 8'h00);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        rx_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("mid-packet reset");
        n_rst = 1'b1;
        clear_held();
        drive(1, 0, 0, 0, 8'h10); idle(1);
        drive(0, 0, 1, 0, 8'h00);
        idle(3);
        chk_zero("after reset tail");

        idle(2);
        chk("dut_a queue drained", qa.size(), 0);
        chk("dut_b queue drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
